// File: rtl/gyro_tilt_ctrl.sv
// gyro_tilt_ctrl
// Sequencer for the gyro tilt integration path. It paces reads from the gyro
// read FSM at a fixed sample period and calibrates a per-axis zero-rate bias
// after reset or a re-zero request. It then delivers bias-corrected, saturated
// rates to the tilt integrator, each with a one-cycle int_en strobe.
//
// Build option:
//   GYRO_DEADBAND_EN - when defined, any corrected axis with |v| <= DEADBAND
//                      is forced to 0 before it is registered into d*.
//                      When undefined, the corrected value passes through
//                      unchanged.
module gyro_tilt_ctrl #(
  parameter int SAMPLE_DIV = 100000,  // CLK cycles per sample tick, >= 4
  parameter int CAL_LOG2   = 4,       // log2 of the calibration sample count
  parameter int TIMEOUT    = 4096,    // max cycles rd_req waits for rd_ack
  parameter int DEADBAND   = 8        // deadband magnitude in raw LSBs
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ZERO,
  output logic               rd_req,
  input  logic               rd_ack,
  input  logic signed [15:0] raw_dx,
  input  logic signed [15:0] raw_dy,
  input  logic signed [15:0] raw_dz,
  output logic signed [15:0] dx,
  output logic signed [15:0] dy,
  output logic signed [15:0] dz,
  output logic               int_en,
  output logic               int_clr,
  output logic               cal_done,
  output logic               err
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int ACC_W  = 16 + CAL_LOG2;
  localparam int CNT_W  = CAL_LOG2 + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CAL_N     = CNT_W'(1 << CAL_LOG2);

  localparam logic signed [15:0] DB_POS = 16'(DEADBAND);
  localparam logic signed [15:0] DB_NEG = -DB_POS;

`ifdef GYRO_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    CLR,
    CAL_WAIT,
    CAL_REQ,
    RUN_WAIT,
    RUN_REQ
  } state_t;

  // Clamp a 17-bit difference into the signed 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return 16'(v);
    end
  endfunction

  // Optional deadband applied after saturation; folds away when disabled.
  function automatic logic signed [15:0] shape(input logic signed [15:0] v);
    if (DB_EN && (v <= DB_POS) && (v >= DB_NEG)) begin
      return '0;
    end else begin
      return v;
    end
  endfunction

  // Registered state
  state_t                    state_q, state_d;
  logic [TICK_W-1:0]         tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]           req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]          cal_cnt_q, cal_cnt_d;
  logic signed [ACC_W-1:0]   acc_q [3];
  logic signed [ACC_W-1:0]   acc_d [3];
  logic signed [15:0]        bias_q [3];
  logic signed [15:0]        bias_d [3];
  logic signed [15:0]        d_q [3];
  logic signed [15:0]        d_d [3];
  logic                      int_en_q, int_en_d;
  logic                      cal_done_q, cal_done_d;
  logic                      err_q, err_d;

  // Combinational helpers
  logic                      tick;
  logic                      timeout;
  logic signed [15:0]        raw [3];
  logic signed [15:0]        corr [3];

  assign raw[0] = raw_dx;
  assign raw[1] = raw_dy;
  assign raw[2] = raw_dz;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign timeout = (req_cnt_q == TO_LAST);

  // Free-running sample-period counter; ZERO deliberately leaves it alone.
  always_comb begin
    if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  // Bias-corrected, saturated (and optionally deadbanded) rate per axis.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      corr[a] = shape(sat16(17'(raw[a]) - 17'(bias_q[a])));
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    req_cnt_d  = '0;
    cal_cnt_d  = cal_cnt_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    d_d        = d_q;
    int_en_d   = 1'b0;
    cal_done_d = cal_done_q;
    err_d      = err_q;

    unique case (state_q)
      CLR: begin
        for (int a = 0; a < 3; a++) begin
          acc_d[a] = '0;
        end
        cal_cnt_d = '0;
        state_d   = CAL_WAIT;
      end

      CAL_WAIT: begin
        if (tick) begin
          state_d = CAL_REQ;
        end
      end

      CAL_REQ: begin
        if (rd_ack) begin
          for (int a = 0; a < 3; a++) begin
            acc_d[a] = acc_q[a] + ACC_W'(raw[a]);
          end
          cal_cnt_d = cal_cnt_q + CNT_W'(1);
          if (cal_cnt_d == CAL_N) begin
            for (int a = 0; a < 3; a++) begin
              bias_d[a] = 16'(acc_d[a] >>> CAL_LOG2);
            end
            cal_done_d = 1'b1;
            state_d    = RUN_WAIT;
          end else begin
            state_d = CAL_WAIT;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = CAL_WAIT;
        end else begin
          req_cnt_d = req_cnt_q + TO_W'(1);
        end
      end

      RUN_WAIT: begin
        if (tick) begin
          state_d = RUN_REQ;
        end
      end

      RUN_REQ: begin
        if (rd_ack) begin
          d_d      = corr;
          int_en_d = 1'b1;
          state_d  = RUN_WAIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RUN_WAIT;
        end else begin
          req_cnt_d = req_cnt_q + TO_W'(1);
        end
      end

      default: begin
        state_d = CLR;
      end
    endcase

    // Re-zero overrides whatever the FSM decided this cycle, including an ack
    // that lands in the same cycle: the sample is discarded.
    if (ZERO) begin
      state_d    = CLR;
      req_cnt_d  = '0;
      cal_cnt_d  = cal_cnt_q;
      acc_d      = acc_q;
      bias_d     = bias_q;
      d_d        = d_q;
      int_en_d   = 1'b0;
      cal_done_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  // State registers with synchronous, active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q    <= CLR;
      tick_cnt_q <= '0;
      req_cnt_q  <= '0;
      cal_cnt_q  <= '0;
      for (int a = 0; a < 3; a++) begin
        acc_q[a]  <= '0;
        bias_q[a] <= '0;
        d_q[a]    <= '0;
      end
      int_en_q   <= 1'b0;
      cal_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      req_cnt_q  <= req_cnt_d;
      cal_cnt_q  <= cal_cnt_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      d_q        <= d_d;
      int_en_q   <= int_en_d;
      cal_done_q <= cal_done_d;
      err_q      <= err_d;
    end
  end

  // Outputs: request and clear are decoded from state, the rest are flops.
  assign rd_req   = (state_q == CAL_REQ) || (state_q == RUN_REQ);
  assign int_clr  = (state_q == CLR);
  assign int_en   = int_en_q;
  assign cal_done = cal_done_q;
  assign err      = err_q;
  assign dx       = d_q[0];
  assign dy       = d_q[1];
  assign dz       = d_q[2];

endmodule

// File: tb/tb_gyro_tilt_ctrl.sv
// Testbench for gyro_tilt_ctrl: directed vectors with hand-computed results.
// Expected integrator outputs are queued when the ack is issued; a monitor
// pops and compares them whenever int_en is seen.
module tb_gyro_tilt_ctrl;

  localparam int SAMPLE_DIV = 10;
  localparam int CAL_LOG2   = 2;
  localparam int TIMEOUT    = 8;
  localparam int DEADBAND   = 8;
  localparam int REQ_WAIT   = 25;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               ZERO = 1'b0;
  logic               rd_req;
  logic               rd_ack = 1'b0;
  logic signed [15:0] raw_dx = '0;
  logic signed [15:0] raw_dy = '0;
  logic signed [15:0] raw_dz = '0;
  logic signed [15:0] dx, dy, dz;
  logic               int_en, int_clr, cal_done, err;

  typedef struct {
    int x;
    int y;
    int z;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cal_x[4];
  int   cal_y[4];
  int   cal_z[4];

  gyro_tilt_ctrl #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .CAL_LOG2  (CAL_LOG2),
    .TIMEOUT   (TIMEOUT),
    .DEADBAND  (DEADBAND)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ZERO    (ZERO),
    .rd_req  (rd_req),
    .rd_ack  (rd_ack),
    .raw_dx  (raw_dx),
    .raw_dy  (raw_dy),
    .raw_dz  (raw_dz),
    .dx      (dx),
    .dy      (dy),
    .dz      (dz),
    .int_en  (int_en),
    .int_clr (int_clr),
    .cal_done(cal_done),
    .err     (err)
  );

  always #5 CLK = ~CLK;

  // Expected output after the optional deadband.
  function automatic int db(input int v);
`ifdef GYRO_DEADBAND_EN
    if (v <= DEADBAND && v >= -DEADBAND) return 0;
`endif
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every int_en strobe must match the oldest queued result.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && int_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL int_en_unexpected: got int_en=1, expected 0 (no result pending)");
      end else begin
        e = exp_q.pop_front();
        check("out_dx", longint'($signed(dx)), e.x);
        check("out_dy", longint'($signed(dy)), e.y);
        check("out_dz", longint'($signed(dz)), e.z);
      end
    end
  end

  // Wait (bounded) at negedges until the DUT raises rd_req.
  task automatic wait_req(input int max_cyc);
    int n = 0;
    while (rd_req !== 1'b1 && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (rd_req !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_req: got rd_req=%b after %0d cycles, expected 1", rd_req, n);
    end
  endtask

  // Answer the pending request; queue the expected result if in run mode.
  task automatic do_ack(input int x, input int y, input int z, input bit run,
                        input int ex, input int ey, input int ez);
    exp_t e;
    raw_dx = 16'(x);
    raw_dy = 16'(y);
    raw_dz = 16'(z);
    rd_ack = 1'b1;
    if (run) begin
      e.x = ex;
      e.y = ey;
      e.z = ez;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    rd_ack = 1'b0;
    raw_dx = 16'sh5A5A;
    raw_dy = 16'sh5A5A;
    raw_dz = 16'sh5A5A;
    check("ack_int_en", int_en, run);
    check("ack_rd_req_fall", rd_req, 0);
  endtask

  task automatic run_ack(input int x, input int y, input int z,
                         input int ex, input int ey, input int ez);
    wait_req(REQ_WAIT);
    do_ack(x, y, z, 1'b1, ex, ey, ez);
  endtask

  // Four calibration acks from cal_x/y/z; cal_done only after the fourth.
  task automatic cal_seq();
    for (int i = 0; i < 4; i++) begin
      wait_req(REQ_WAIT);
      do_ack(cal_x[i], cal_y[i], cal_z[i], 1'b0, 0, 0, 0);
      check("cal_done_step", cal_done, (i == 3) ? 1 : 0);
    end
  endtask

  // Called at the first negedge with rd_req high; let the request expire.
  task automatic expect_timeout();
    int n = 0;
    while (rd_req === 1'b1 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    check("timeout_len", n, TIMEOUT);
    check("timeout_err", err, 1);
    check("timeout_no_int_en", int_en, 0);
  endtask

  task automatic pulse_zero();
    ZERO = 1'b1;
    @(negedge CLK);
    ZERO = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_int_clr", int_clr, 1);
    check("rst_rd_req", rd_req, 0);
    check("rst_int_en", int_en, 0);
    check("rst_cal_done", cal_done, 0);
    check("rst_err", err, 0);
    check("rst_dx", longint'($signed(dx)), 0);
    check("rst_dy", longint'($signed(dy)), 0);
    check("rst_dz", longint'($signed(dz)), 0);
    RST = 1'b0;
    @(negedge CLK);
    check("clr_one_cycle", int_clr, 0);

    // Calibration: bias = (10, -3, 2), then one run sample
    cal_x = '{4, 8, 12, 16};
    cal_y = '{-3, -3, -3, -3};
    cal_z = '{1, 2, 3, 4};
    cal_seq();
    run_ack(25, 0, 0, db(15), db(3), db(-2));

    // Stray ack in RUN_WAIT, right after the strobe
    raw_dx = 16'sd1000;
    raw_dy = 16'sd1000;
    raw_dz = 16'sd1000;
    rd_ack = 1'b1;
    @(negedge CLK);
    rd_ack = 1'b0;
    check("stray_int_en", int_en, 0);
    check("stray_rd_req", rd_req, 0);
    check("stray_dx_hold", longint'($signed(dx)), db(15));
    @(negedge CLK);
    check("stray_int_en2", int_en, 0);
    check("stray_rd_req2", rd_req, 0);

    // Read timeout in RUN_REQ, then next tick re-issues the request
    wait_req(REQ_WAIT);
    expect_timeout();
    wait_req(REQ_WAIT);
    check("err_sticky_req", err, 1);
    do_ack(0, 0, 0, 1'b1, db(-10), db(3), db(-2));
    check("err_sticky_ack", err, 1);

    // ZERO during RUN_REQ
    wait_req(REQ_WAIT);
    pulse_zero();
    check("zero_rd_req", rd_req, 0);
    check("zero_int_clr", int_clr, 1);
    check("zero_cal_done", cal_done, 0);
    check("zero_err", err, 0);
    @(negedge CLK);
    check("zero_int_clr_once", int_clr, 0);

    // Recalibrate with one timed-out read; bias = (-100, 0, 0)
    wait_req(REQ_WAIT);
    expect_timeout();
    check("cal_timeout_no_done", cal_done, 0);
    cal_x = '{-100, -100, -100, -100};
    cal_y = '{0, 0, 0, 0};
    cal_z = '{0, 0, 0, 0};
    cal_seq();
    run_ack(32767, -32768, 5, 32767, -32768, db(5));
    run_ack(0, 0, -9, 100, 0, db(-9));
    run_ack(0, 0, 8, 100, 0, db(8));

    // Recalibrate with bias = (100, 0, 0); negative saturation
    pulse_zero();
    cal_x = '{100, 100, 100, 100};
    cal_seq();
    run_ack(-32768, 32767, 9, -32768, 32767, 9);
    repeat (3) @(negedge CLK);
    check("d_hold", longint'($signed(dx)), -32768);

    // Reset mid-operation
    RST = 1'b1;
    @(negedge CLK);
    check("rst2_dx", longint'($signed(dx)), 0);
    check("rst2_cal_done", cal_done, 0);
    check("rst2_int_clr", int_clr, 1);
    check("rst2_rd_req", rd_req, 0);
    RST = 1'b0;
    @(negedge CLK);

    check("results_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gyro_tilt_ctrl.md
# gyro_tilt_ctrl

Sequencer for the gyro tilt integration path. Paces angular-velocity reads from the gyro read FSM at a fixed sample period and calibrates a per-axis zero-rate bias at power-up or on request. Delivers bias-corrected, saturated rates to the tilt integrator with a one-cycle integrate strobe, and clears the integrator whenever the reference is re-zeroed. Sits between the gyro read FSM (upstream) and the tilt integrator (downstream).

## Interface
- SAMPLE_DIV, 100000: CLK cycles per sample tick (1 ms at 100 MHz); must be ≥ 4.
- CAL_LOG2, 4: log2 of the number of calibration samples (16).
- TIMEOUT, 4096: maximum cycles `rd_req` is held waiting for `rd_ack`.
- DEADBAND, 8: deadband magnitude in raw LSBs; used only with `GYRO_DEADBAND_EN`.

- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- ZERO  in  1  re-zero request (level or pulse); restarts clear + calibration
- rd_req  out  1  read request to the gyro FSM
- rd_ack  in  1  one-cycle pulse; `raw_*` valid in the same cycle
- raw_dx, raw_dy, raw_dz  in  16 each  signed raw angular rate
- dx, dy, dz  out  16 each  signed bias-corrected rate to the integrator
- int_en  out  1  one-cycle strobe; integrator adds `d*` in this cycle
- int_clr  out  1  integrator clear
- cal_done  out  1  bias valid; normal sampling active
- err  out  1  sticky read-timeout flag; cleared by RST or ZERO

## Operation
- States: CLR, CAL_WAIT, CAL_REQ, RUN_WAIT, RUN_REQ.
- Reset values:
  - State is CLR.
  - `rd_req`, `int_en`, `cal_done` and `err` are 0.
  - `dx`, `dy`, `dz` are 0.
  - Accumulators, biases and sample count are 0.
  - `int_clr` is 1, decoded from state == CLR.
- CLR:
  - Held for exactly one cycle after RST is released; `int_clr` = 1.
  - Clears the accumulators and sample count, then goes to CAL_WAIT.
- Tick counter:
  - Free-running from 0 to SAMPLE_DIV-1; `tick` is high at SAMPLE_DIV-1, then the counter wraps to 0.
  - Not reset by ZERO.
- CAL_WAIT/RUN_WAIT: on `tick`, go to the matching REQ state.
- REQ states:
  - Hold `rd_req` = 1 and count the cycles spent in the state.
  - `rd_ack` is ignored outside the REQ states.
- CAL_REQ on `rd_ack`:
  - Add `raw_*` (sign-extended) to 16+CAL_LOG2-bit accumulators and increment the count.
  - When the count reaches 2^CAL_LOG2: `bias_* = acc_* >>> CAL_LOG2` (arithmetic shift, truncated), set `cal_done` = 1, go to RUN_WAIT.
  - Otherwise return to CAL_WAIT.
- RUN_REQ on `rd_ack`:
  - Compute `raw_* - bias_*` at 17 bits, saturated to the range [-32768, 32767].
  - Register the result into `d*`, pulse `int_en`, go to RUN_WAIT.
- Timeout:
  - Triggered when the REQ-cycle count reaches TIMEOUT with no `rd_ack`.
  - Drop `rd_req`, set `err` = 1, discard the sample (no accumulate, no `int_en`), return to the matching WAIT state.
- Ticks arriving while in a REQ state are dropped, not queued.
- ZERO:
  - Sampled every cycle and overrides all transitions.
  - Next state is CLR, with `cal_done` = 0 and `err` = 0.
  - Any outstanding request is abandoned; `rd_req` is 0 in CLR.
- RST mid-operation: same as ZERO, plus all registers return to their reset values.
- `d*` holds its last value between strobes.

## Timing
- `rd_req` rises the cycle after `tick` and falls the cycle after `rd_ack`. Simultaneous `rd_ack` and timeout: the ack wins.
- Results from an ack in cycle N:
  - Run mode: `d*` updated and `int_en` = 1 in cycle N+1, for one cycle only.
  - Calibration: bias and `cal_done` valid in cycle N+1.
- Only one outstanding request at a time; at most one `int_en` per tick period.
- Calibration takes 2^CAL_LOG2 ticks after CLR, ignoring any dropped or timed-out reads.

## Configuration
- `GYRO_DEADBAND_EN` defined: after saturation, any corrected axis with |v| ≤ DEADBAND outputs 0. Implemented as a combinational compare ahead of the `d*` registers; latency unchanged.
- Not defined: the corrected value passes through unmodified. The DEADBAND parameter is unused.

## Test plan
Bench parameters: SAMPLE_DIV=10, CAL_LOG2=2, TIMEOUT=8.
- Calibration + run: RST, then 4 acks with `raw_dx` = 4, 8, 12, 16 → `bias_x` = 10 and `cal_done` = 1. Next ack with `raw_dx` = 25 → `dx` = 15 and a single-cycle `int_en` one cycle after the ack.
- Saturation: calibrate with `raw_dx` = -100 for all samples; run ack with `raw_dx` = 32767 → `dx` = 32767. Calibrate with 100; run ack with -32768 → `dx` = -32768.
- Timeout: in RUN_REQ with no ack → `rd_req` falls after 8 cycles, `err` = 1, no `int_en`. Next tick re-issues `rd_req`; `err` stays 1.
- ZERO during RUN_REQ: next cycle `rd_req` = 0, `int_clr` = 1 for one cycle, `cal_done` = 0, `err` = 0. Exactly 4 new acks are needed before `cal_done` returns to 1.
- Deadband (bias 0, DEADBAND=8): with `GYRO_DEADBAND_EN`, raw 5 → `dx` = 0 and raw -9 → -9. Without the macro, raw 5 → 5.
- Stray ack: `rd_ack` pulse in RUN_WAIT → no state change, no `int_en`, `d*` unchanged.
